// File: rtl/mas_arith_pkg.sv
// rtl/mas_arith_pkg.sv - shared arithmetic word and sum types for the MAS adder slice
package mas_arith_pkg;

  localparam int MAS_ADD_W = 16;

  typedef logic [MAS_ADD_W-1:0] mas_word_t;

  typedef struct packed {
    mas_word_t res;
    logic      cout;
  } mas_sum_t;

endpackage

// File: rtl/mas_ripple_carry_adder_16b.sv
// rtl/mas_ripple_carry_adder_16b.sv - 16-bit ripple-carry adder, {cout,sum} = a + b + cin
module mas_ripple_carry_adder_16b
  import mas_arith_pkg::*;
(
  input  logic [MAS_ADD_W-1:0] a_i,
  input  logic [MAS_ADD_W-1:0] b_i,
  input  logic                 cin_i,
  output logic [MAS_ADD_W-1:0] sum_o,
  output logic                 cout_o
);

  logic [MAS_ADD_W:0] carry;

  assign carry[0] = cin_i;

  for (genvar i = 0; i < MAS_ADD_W; i++) begin : g_fa
    assign sum_o[i]     = a_i[i] ^ b_i[i] ^ carry[i];
    assign carry[i + 1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
  end

  assign cout_o = carry[MAS_ADD_W];

endmodule

// File: rtl/mas_rr_arbiter.sv
// rtl/mas_rr_arbiter.sv - combinational round-robin pick: first set req at or above ptr, wrapping
module mas_rr_arbiter #(
  parameter  int N   = 4,
  localparam int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  input  logic           en,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_idx
);

  logic           found;
  logic [IDW:0]   pos;
  logic [IDW-1:0] cand;

  // gnt_idx falls back to 0 when nothing is requested so the operand mux has a defined select
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    pos     = '0;
    cand    = '0;
    for (int off = 0; off < N; off++) begin
      pos = {1'b0, ptr} + (IDW + 1)'(off);
      if (pos >= (IDW + 1)'(N)) begin
        pos = pos - (IDW + 1)'(N);
      end
      cand = pos[IDW-1:0];
      if (!found && req[cand]) begin
        found   = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  assign gnt = (found && en) ? (N'(1) << gnt_idx) : '0;

endmodule

// File: rtl/mas_adder_share_arbiter.sv
// rtl/mas_adder_share_arbiter.sv - round-robin sharing of one 16-bit adder with a registered response
module mas_adder_share_arbiter
  import mas_arith_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*16-1:0]   req_in1,
  input  logic [NUM_REQ*16-1:0]   req_in2,
  input  logic [NUM_REQ-1:0]      req_cin,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [MAS_ADD_W-1:0]    rsp_res,
  output logic                    rsp_cout,
  output logic [15:0]             op_count
);

  logic                 rsp_valid_q, rsp_valid_d;
  mas_sum_t             sum_q, sum_d;
  logic [ID_W-1:0]      id_q, id_d;
  logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [15:0]          cnt_q, cnt_d;

  logic                 can_accept;
  logic                 accept;
  logic [NUM_REQ-1:0]   gnt;
  logic [ID_W-1:0]      gnt_idx;
  mas_word_t            op_a, op_b;
  logic                 op_cin;
  mas_word_t            add_sum;
  logic                 add_cout;

  // Gating with rst_n keeps req_ready low for the whole time reset is asserted
  assign can_accept = !rsp_valid_q || rsp_ready;

  mas_rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req     (req_valid),
    .ptr     (rr_ptr_q),
    .en      (can_accept && rst_n),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign accept = |(req_valid & gnt);

  always_comb begin
    op_a   = req_in1[15:0];
    op_b   = req_in2[15:0];
    op_cin = req_cin[0];
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx == ID_W'(i)) begin
        op_a   = req_in1[16*i +: 16];
        op_b   = req_in2[16*i +: 16];
        op_cin = req_cin[i];
      end
    end
  end

  mas_ripple_carry_adder_16b u_add (
    .a_i    (op_a),
    .b_i    (op_b),
    .cin_i  (op_cin),
    .sum_o  (add_sum),
    .cout_o (add_cout)
  );

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    sum_d       = sum_q;
    id_d        = id_q;
    rr_ptr_d    = rr_ptr_q;
    cnt_d       = cnt_q;

    if (rsp_valid_q && rsp_ready && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end

    if (accept) begin
      rsp_valid_d = 1'b1;
      sum_d.res   = add_sum;
      sum_d.cout  = add_cout;
      id_d        = gnt_idx;
      rr_ptr_d    = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      sum_q       <= '0;
      id_q        <= '0;
      rr_ptr_q    <= '0;
      cnt_q       <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      sum_q       <= sum_d;
      id_q        <= id_d;
      rr_ptr_q    <= rr_ptr_d;
      cnt_q       <= cnt_d;
    end
  end

  assign req_ready = gnt;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = id_q;
  assign rsp_res   = sum_q.res;
  assign rsp_cout  = sum_q.cout;
  assign op_count  = cnt_q;

endmodule

// File: tb/tb_mas_adder_share_arbiter.sv
// tb/tb_mas_adder_share_arbiter.sv - self-checking bench for mas_adder_share_arbiter
module tb_mas_adder_share_arbiter;

  localparam int N = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N*16-1:0] req_in1 = '0;
  logic [N*16-1:0] req_in2 = '0;
  logic [N-1:0]    req_cin = '0;
  logic            rsp_valid;
  logic            rsp_ready = 1'b1;
  logic [1:0]      rsp_id;
  logic [15:0]     rsp_res;
  logic            rsp_cout;
  logic [15:0]     op_count;

  int n_tests = 0;
  int n_fail  = 0;

  mas_adder_share_arbiter #(.NUM_REQ(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_in1   (req_in1),
    .req_in2   (req_in2),
    .req_cin   (req_cin),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_res   (rsp_res),
    .rsp_cout  (rsp_cout),
    .op_count  (op_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pending response slot, pointer and counter
  int m_valid = 0, m_id = 0, m_res = 0, m_cout = 0, m_cnt = 0, m_ptr = 0;
  int n_valid = 0, n_id = 0, n_res = 0, n_cout = 0, n_cnt = 0, n_ptr = 0;
  int g, exp_rdy, s;
  bit can;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_valid", 32'(rsp_valid), 0);
      chk("rst_id", 32'(rsp_id), 0);
      chk("rst_res", 32'(rsp_res), 0);
      chk("rst_cout", 32'(rsp_cout), 0);
      chk("rst_count", 32'(op_count), 0);
      chk("rst_ready", 32'(req_ready), 0);
      n_valid = 0; n_id = 0; n_res = 0; n_cout = 0; n_cnt = 0; n_ptr = 0;
    end else begin
      chk("m_valid", 32'(rsp_valid), m_valid);
      chk("m_id", 32'(rsp_id), m_id);
      chk("m_res", 32'(rsp_res), m_res);
      chk("m_cout", 32'(rsp_cout), m_cout);
      chk("m_count", 32'(op_count), m_cnt);
      can = (m_valid == 0) || rsp_ready;
      g = -1;
      for (int off = 0; off < N; off++) begin
        if (g < 0 && req_valid[(m_ptr + off) % N]) g = (m_ptr + off) % N;
      end
      exp_rdy = (can && g >= 0) ? (1 << g) : 0;
      chk("m_ready", 32'(req_ready), exp_rdy);
      n_valid = m_valid; n_id = m_id; n_res = m_res; n_cout = m_cout; n_ptr = m_ptr;
      n_cnt = m_cnt + ((m_valid != 0 && rsp_ready && m_cnt < 65535) ? 1 : 0);
      if (exp_rdy != 0) begin
        s = int'(req_in1[16*g +: 16]) + int'(req_in2[16*g +: 16]) + int'(req_cin[g]);
        n_valid = 1;
        n_id    = g;
        n_res   = s & 'hFFFF;
        n_cout  = s >> 16;
        n_ptr   = (g + 1) % N;
      end else if (rsp_ready) begin
        n_valid = 0;
      end
    end
  end

  always @(posedge clk) begin
    m_valid <= n_valid; m_id <= n_id; m_res <= n_res;
    m_cout <= n_cout; m_cnt <= n_cnt; m_ptr <= n_ptr;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b,
                         input logic c, input logic v);
    req_in1[16*i +: 16] = a;
    req_in2[16*i +: 16] = b;
    req_cin[i]          = c;
    req_valid[i]        = v;
  endtask

  initial begin
    // Reset and idle
    #1 rst_n = 1'b0;
    repeat (3) tick;
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_ready", 32'(req_ready), 0);
    chk("idle_valid", 32'(rsp_valid), 0);
    chk("idle_count", 32'(op_count), 0);

    // Single op from requester 2
    tick;
    set_req(2, 16'hFFFF, 16'h0001, 1'b0, 1'b1);
    @(negedge clk);
    chk("single_ready", 32'(req_ready), 'b0100);
    tick;
    req_valid = '0;
    @(negedge clk);
    chk("single_valid", 32'(rsp_valid), 1);
    chk("single_id", 32'(rsp_id), 2);
    chk("single_res", 32'(rsp_res), 'h0000);
    chk("single_cout", 32'(rsp_cout), 1);
    tick;
    @(negedge clk);
    chk("drain_valid", 32'(rsp_valid), 0);
    chk("drain_count", 32'(op_count), 1);
    chk("drain_hold_id", 32'(rsp_id), 2);

    // Carry-in and pointer wrap from requester 3
    tick;
    set_req(3, 16'h7FFF, 16'h8000, 1'b1, 1'b1);
    set_req(0, 16'h1234, 16'h1111, 1'b0, 1'b1);
    set_req(1, 16'h8000, 16'h8000, 1'b1, 1'b1);
    @(negedge clk);
    chk("wrap_ready3", 32'(req_ready), 'b1000);
    tick;
    req_valid[3] = 1'b0;
    @(negedge clk);
    chk("wrap_res", 32'(rsp_res), 'h0000);
    chk("wrap_cout", 32'(rsp_cout), 1);
    chk("wrap_id", 32'(rsp_id), 3);
    chk("wrap_next", 32'(req_ready), 'b0001);
    tick;
    req_valid[0] = 1'b0;
    @(negedge clk);
    chk("wrap_res0", 32'(rsp_res), 'h2345);
    chk("wrap_next1", 32'(req_ready), 'b0010);
    tick;
    req_valid = '0;
    @(negedge clk);
    chk("wrap_res1", 32'(rsp_res), 'h0001);
    chk("wrap_cout1", 32'(rsp_cout), 1);
    tick;

    // Round-robin with all requesters valid
    rst_n = 1'b0;
    tick;
    tick;
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) begin
      set_req(i, 16'(16'h1111 * (i + 1)), 16'(16'h4000 * i + 16'h00FF), i[0], 1'b1);
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("rr_grant", 32'(req_ready), 32'(1 << (k % 4)));
      if (k > 0) chk("rr_valid", 32'(rsp_valid), 1);
      tick;
    end
    req_valid = '0;
    @(negedge clk);
    chk("rr_last_id", 32'(rsp_id), 0);
    chk("rr_last_res", 32'(rsp_res), 'h1210);
    chk("rr_count4", 32'(op_count), 4);
    tick;
    @(negedge clk);
    chk("rr_count5", 32'(op_count), 5);
    chk("rr_drained", 32'(rsp_valid), 0);

    // Backpressure with a response from requester 1 pending
    tick;
    req_valid = '1;
    @(negedge clk);
    chk("bp_grant", 32'(req_ready), 'b0010);
    tick;
    rsp_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      chk("bp_ready", 32'(req_ready), 0);
      chk("bp_valid", 32'(rsp_valid), 1);
      chk("bp_id", 32'(rsp_id), 1);
      chk("bp_res", 32'(rsp_res), 'h6322);
      chk("bp_count", 32'(op_count), 5);
      tick;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_ptr_frozen", 32'(req_ready), 'b0100);
    tick;

    // Reset while a response is stalled
    rsp_ready = 1'b0;
    @(negedge clk);
    chk("mid_pending", 32'(rsp_valid), 1);
    tick;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(rsp_valid), 0);
    chk("mid_rst_count", 32'(op_count), 0);
    chk("mid_rst_ready", 32'(req_ready), 0);
    tick;
    rst_n = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b1;
    tick;
    tick;
    @(negedge clk);
    chk("post_rst_ready", 32'(req_ready), 0);
    chk("post_rst_valid", 32'(rsp_valid), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
